// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding selects, load-use and MDU
// stalls, and branch flush, driven from ID decode plus a shadow scoreboard of EX/MEM dests.
module hazard_fwd_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] iRs,
    input  logic [4:0] iRt,
    input  logic       iUseRs,
    input  logic       iUseRt,
    input  logic       iWen,
    input  logic [4:0] iRd,
    input  logic       iIsLoad,
    input  logic       iMdStart,
    input  logic       iRdHiLo,
    input  logic       iBranchTaken,
    output logic [1:0] oFwdA,
    output logic [1:0] oFwdB,
    output logic       oStall,
    output logic       oFlush,
    output logic       oMdBusy
);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    logic             ex_wen_q, ex_load_q, mem_wen_q;
    logic [4:0]       ex_rd_q, mem_rd_q;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    md_state_e        md_state_q, md_state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             ldu, mdhaz, issue;

    // Youngest producer wins; a load still in EX cannot forward (its data appears after MEM).
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                           input logic exw, input logic [4:0] exr,
                                           input logic exl, input logic mw,
                                           input logic [4:0] mr);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (src != 5'd0)) begin
            if (exw && (exr == src) && !exl)
                sel = 2'b01;
            else if (mw && (mr == src))
                sel = 2'b10;
        end
        return sel;
    endfunction

    assign oMdBusy = (md_state_q == MD_BUSY);
    assign oFwdA   = fwd_a_q;
    assign oFwdB   = fwd_b_q;

    always_comb begin
        ldu    = ex_wen_q && ex_load_q && (ex_rd_q != 5'd0) &&
                 ((iUseRs && (iRs == ex_rd_q)) || (iUseRt && (iRt == ex_rd_q)));
        mdhaz  = oMdBusy && (iRdHiLo || iMdStart);
        oStall = (ldu || mdhaz) && !iBranchTaken;
        oFlush = iBranchTaken;
        issue  = !oStall && !iBranchTaken;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (issue) begin
            fwd_a_d = fwd_sel(iUseRs, iRs, ex_wen_q, ex_rd_q, ex_load_q, mem_wen_q, mem_rd_q);
            fwd_b_d = fwd_sel(iUseRt, iRt, ex_wen_q, ex_rd_q, ex_load_q, mem_wen_q, mem_rd_q);
        end
    end

    // MDU occupancy counter keeps running through stalls and flushes.
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        case (md_state_q)
            MD_IDLE: begin
                if (iMdStart && issue) begin
                    md_state_d = MD_BUSY;
                    md_cnt_d   = CNT_W'(MD_LAT);
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - CNT_W'(1);
                if (md_cnt_q == CNT_W'(1))
                    md_state_d = MD_IDLE;
            end
            default: md_state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wen_q   <= 1'b0;
            ex_load_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            fwd_a_q    <= 2'b00;
            fwd_b_q    <= 2'b00;
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
        end else begin
            ex_wen_q   <= iWen && issue;
            ex_load_q  <= iIsLoad;
            mem_wen_q  <= ex_wen_q;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

    // Destination tags are only meaningful when the matching wen bit is set.
    always_ff @(posedge clk) begin
        ex_rd_q  <= iRd;
        mem_rd_q <= ex_rd_q;
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: a pipeline-history model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_fwd_ctrl;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] iRs, iRt, iRd;
    logic       iUseRs, iUseRt, iWen, iIsLoad, iMdStart, iRdHiLo, iBranchTaken;
    logic [1:0] oFwdA, oFwdB;
    logic       oStall, oFlush, oMdBusy;

    hazard_fwd_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .iRs(iRs), .iRt(iRt), .iUseRs(iUseRs), .iUseRt(iUseRt),
        .iWen(iWen), .iRd(iRd), .iIsLoad(iIsLoad), .iMdStart(iMdStart), .iRdHiLo(iRdHiLo),
        .iBranchTaken(iBranchTaken), .oFwdA(oFwdA), .oFwdB(oFwdB), .oStall(oStall),
        .oFlush(oFlush), .oMdBusy(oMdBusy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       stall, flush, busy;
    } exp_t;

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic       use_rs, use_rt, wen, load, md, hilo, br;
    } instr_t;

    typedef struct packed {
        logic       wen;
        logic [4:0] rd;
        logic       load;
    } ent_t;

    exp_t   sb_q[$];
    ent_t   hist[$];          // hist[0]: instruction now in EX, hist[1]: now in MEM
    logic [1:0] m_fa, m_fb;
    int     m_md_rem;
    logic   last_stall;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("fwdA",  oFwdA, e.fa);
            chk("fwdB",  oFwdB, e.fb);
            chk("stall", {1'b0, oStall}, {1'b0, e.stall});
            chk("flush", {1'b0, oFlush}, {1'b0, e.flush});
            chk("mdbusy", {1'b0, oMdBusy}, {1'b0, e.busy});
        end
    end

    task automatic model_reset();
        ent_t b;
        b = '0;
        hist.delete();
        hist.push_back(b);
        hist.push_back(b);
        m_fa = 2'b00;
        m_fb = 2'b00;
        m_md_rem = 0;
        last_stall = 1'b0;
    endtask

    function automatic logic [1:0] src_sel(input logic ok, input logic use_src, input logic [4:0] src);
        if (!ok || !use_src || src == 5'd0) return 2'b00;
        if (hist[0].wen && hist[0].rd == src && !hist[0].load) return 2'b01;
        if (hist[1].wen && hist[1].rd == src) return 2'b10;
        return 2'b00;
    endfunction

    // Called at posedge+1: present one ID-stage instruction for one cycle, advance the model.
    task automatic drive(input instr_t in);
        exp_t e;
        ent_t n;
        logic ldu, busy, stall, issue;
        iRs = in.rs; iRt = in.rt; iRd = in.rd; iUseRs = in.use_rs; iUseRt = in.use_rt;
        iWen = in.wen; iIsLoad = in.load; iMdStart = in.md; iRdHiLo = in.hilo;
        iBranchTaken = in.br;
        busy  = (m_md_rem > 0);
        ldu   = hist[0].wen && hist[0].load && hist[0].rd != 5'd0 &&
                ((in.use_rs && in.rs == hist[0].rd) || (in.use_rt && in.rt == hist[0].rd));
        stall = (ldu || (busy && (in.hilo || in.md))) && !in.br;
        e.fa = m_fa; e.fb = m_fb; e.stall = stall; e.flush = in.br; e.busy = busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        issue = !stall && !in.br;
        m_fa = src_sel(issue, in.use_rs, in.rs);
        m_fb = src_sel(issue, in.use_rt, in.rt);
        if (m_md_rem > 0) m_md_rem--;
        else if (in.md && issue) m_md_rem = MD_LAT;
        n = '0;
        if (issue) begin
            n.wen = in.wen; n.rd = in.rd; n.load = in.load;
        end
        hist.push_front(n);
        void'(hist.pop_back());
        last_stall = stall;
    endtask

    // Re-present a stalled instruction until it issues (a taken branch squashes it instead).
    task automatic send(input instr_t in);
        int guard;
        guard = 0;
        do begin
            drive(in);
            guard++;
        end while (last_stall && guard < 64);
        if (guard >= 64) begin
            errors++;
            $display("FAIL stall_bound: got %0d cycles expected fewer than 64", guard);
        end
    endtask

    task automatic do_reset();
        exp_t z;
        z = '0;
        iRs = '0; iRt = '0; iRd = '0; iUseRs = 0; iUseRt = 0; iWen = 0; iIsLoad = 0;
        iMdStart = 0; iRdHiLo = 0; iBranchTaken = 0;
        rst = 1'b1;
        model_reset();
        sb_q.push_back(z);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic instr_t mk(input logic [4:0] rd, input logic wen, input logic load,
                                  input logic [4:0] rs, input logic urs,
                                  input logic [4:0] rt, input logic urt);
        instr_t i;
        i = '0;
        i.rd = rd; i.wen = wen; i.load = load;
        i.rs = rs; i.use_rs = urs; i.rt = rt; i.use_rt = urt;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        i = '0;
        i.rs = 5'($urandom_range(0, 3));
        i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3));
        i.use_rs = ($urandom_range(0, 3) != 0);
        i.use_rt = ($urandom_range(0, 2) != 0);
        i.wen  = ($urandom_range(0, 9) < 7);
        i.load = i.wen && ($urandom_range(0, 9) < 3);
        i.md   = ($urandom_range(0, 99) < 6);
        i.hilo = !i.md && ($urandom_range(0, 9) == 0);
        i.br   = ($urandom_range(0, 99) < 8);
        return i;
    endfunction

    initial begin
        instr_t nop, t;
        nop = '0;
        rst = 1'b1;
        iRs = '0; iRt = '0; iRd = '0; iUseRs = 0; iUseRt = 0; iWen = 0; iIsLoad = 0;
        iMdStart = 0; iRdHiLo = 0; iBranchTaken = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // back-to-back ALU dependency
        send(mk(5'd3, 1, 0, 5'd1, 1, 5'd2, 1));
        send(mk(5'd4, 1, 0, 5'd3, 1, 5'd3, 1));
        send(nop); send(nop); send(nop);
        // one and two gaps
        send(mk(5'd3, 1, 0, 5'd0, 0, 5'd0, 0));
        send(nop);
        send(mk(5'd5, 1, 0, 5'd3, 1, 5'd1, 1));
        send(mk(5'd3, 1, 0, 5'd0, 0, 5'd0, 0));
        send(nop); send(nop);
        send(mk(5'd5, 1, 0, 5'd3, 1, 5'd3, 1));
        // load-use, then load to r0
        send(mk(5'd2, 1, 1, 5'd1, 1, 5'd0, 0));
        send(mk(5'd6, 1, 0, 5'd2, 1, 5'd2, 1));
        send(mk(5'd0, 1, 1, 5'd1, 1, 5'd0, 0));
        send(mk(5'd6, 1, 0, 5'd0, 1, 5'd0, 1));
        send(nop); send(nop);
        // mult then mflo
        t = nop; t.md = 1'b1;
        send(t);
        t = mk(5'd7, 1, 0, 5'd0, 0, 5'd0, 0); t.hilo = 1'b1;
        send(t);
        send(nop);
        // load-use coinciding with a taken branch
        send(mk(5'd2, 1, 1, 5'd1, 1, 5'd0, 0));
        t = mk(5'd6, 1, 0, 5'd2, 1, 5'd2, 1); t.br = 1'b1;
        send(t);
        send(nop); send(nop);
        // reset while MDU busy with a forward pending
        t = nop; t.md = 1'b1;
        send(t);
        send(mk(5'd3, 1, 0, 5'd0, 0, 5'd0, 0));
        send(mk(5'd4, 1, 0, 5'd3, 1, 5'd3, 1));
        do_reset();
        send(nop); send(nop);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else send(rnd());
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
